// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the IF stage: default vectors, FSM state encoding
// and a word-alignment helper.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: exception vector beats branch target,
// which beats sequential pc+4 (taken only when the current fetch completes).
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        branch,
  input  logic [31:0] branch_tgt,
  input  logic        ack,
  output logic        redir,
  output logic [31:0] redir_tgt,
  output logic [31:0] next_pc
);

  always_comb begin
    redir = exception | branch;
    if (exception) redir_tgt = EXC_VEC;
    else           redir_tgt = word_align(branch_tgt);
    if (redir)     next_pc = redir_tgt;
    else if (ack)  next_pc = pc + 32'd4;
    else           next_pc = pc;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the PC, runs the imem req/ack handshake and drives the
// IF/ID register, squashing the in-flight fetch on branch or exception.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_branch,
  input  logic [31:0] in_branch_tgt,
  input  logic        in_exception,
  input  logic        in_stall,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;

  pc_next_sel #(.EXC_VEC(EXC_VEC)) u_next_sel (
    .pc         (pc),
    .exception  (in_exception),
    .branch     (in_branch),
    .branch_tgt (in_branch_tgt),
    .ack        (in_imem_ack),
    .redir      (redir),
    .redir_tgt  (redir_tgt),
    .next_pc    (next_pc)
  );

  // The fetch address is the PC itself; in DISCARD the PC is left untouched
  // so the abandoned request keeps a stable address until it is acked.
  assign out_imem_addr = pc;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state        <= IF_IDLE;
      pc           <= RESET_VEC;
      pend_pc      <= 32'd0;
      out_imem_req <= 1'b0;
      out_valid    <= 1'b0;
      out_inst     <= 32'd0;
      out_pc       <= 32'd0;
      buf_valid    <= 1'b0;
      buf_inst     <= 32'd0;
      buf_pc       <= 32'd0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (redir) begin
            pc        <= redir_tgt;
            out_valid <= 1'b0;
          end
          state        <= IF_FETCH;
          out_imem_req <= 1'b1;
        end
        IF_FETCH: begin
          if (in_imem_ack && !redir) begin
            pc <= next_pc;
            if (!in_stall || !out_valid) begin
              out_inst  <= in_imem_rdata;
              out_pc    <= pc;
              out_valid <= 1'b1;
            end else begin
              buf_inst  <= in_imem_rdata;
              buf_pc    <= pc;
              buf_valid <= 1'b1;
            end
            if (in_stall) begin
              state        <= IF_HOLD;
              out_imem_req <= 1'b0;
            end
          end else if (in_imem_ack && redir) begin
            pc        <= next_pc;
            out_valid <= 1'b0;
          end else if (redir) begin
            pend_pc   <= redir_tgt;
            out_valid <= 1'b0;
            state     <= IF_DISCARD;
          end
        end
        IF_HOLD: begin
          if (redir) begin
            pc           <= redir_tgt;
            out_valid    <= 1'b0;
            buf_valid    <= 1'b0;
            state        <= IF_FETCH;
            out_imem_req <= 1'b1;
          end else if (!in_stall) begin
            if (buf_valid) begin
              out_inst  <= buf_inst;
              out_pc    <= buf_pc;
              out_valid <= 1'b1;
              buf_valid <= 1'b0;
            end
            state        <= IF_FETCH;
            out_imem_req <= 1'b1;
          end
        end
        IF_DISCARD: begin
          // A newer redirect replaces the pending target, even on the ack cycle.
          if (redir) begin
            pend_pc <= redir_tgt;
            if (in_imem_ack) begin
              pc    <= redir_tgt;
              state <= IF_FETCH;
            end
          end else if (in_imem_ack) begin
            pc    <= pend_pc;
            state <= IF_FETCH;
          end
        end
        default: begin
          state        <= IF_IDLE;
          out_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequential fetch, redirects,
// stall buffering, exception priority, PC wrap and asynchronous reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic [31:0] branch_tgt;
  logic        exception;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_branch     (branch),
    .in_branch_tgt (branch_tgt),
    .in_exception  (exception),
    .in_stall      (stall),
    .out_imem_req  (imem_req),
    .out_imem_addr (imem_addr),
    .in_imem_ack   (imem_ack),
    .in_imem_rdata (imem_rdata),
    .out_valid     (valid),
    .out_inst      (inst),
    .out_pc        (pc)
  );

  // Memory returns the bitwise inverse of the address as the instruction word.
  assign imem_rdata = ~imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch = 1'b0; branch_tgt = 32'd0; exception = 1'b0;
    stall = 1'b0; imem_ack = 1'b1;
    step(); step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
    total++; if (inst !== 32'd0 || pc !== 32'd0) begin bad++; $display("[TB] FAIL reset_regs: got inst=%h pc=%h want 0/0", inst, pc); end
    rst_n = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000 || valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_c1: got req=%b addr=%h valid=%b want 1/bfc00000/0", imem_req, imem_addr, valid); end
    step();
    total++; if (imem_addr !== 32'hBFC0_0004 || valid !== 1'b1 || pc !== 32'hBFC0_0000 || inst !== ~32'hBFC0_0000) begin bad++; $display("[TB] FAIL seq_c2: got addr=%h valid=%b pc=%h inst=%h", imem_addr, valid, pc, inst); end
    step();
    total++; if (imem_addr !== 32'hBFC0_0008 || valid !== 1'b1 || pc !== 32'hBFC0_0004) begin bad++; $display("[TB] FAIL seq_c3: got addr=%h valid=%b pc=%h want bfc00008/1/bfc00004", imem_addr, valid, pc); end
  endtask

  task automatic test_branch();
    branch = 1'b1; branch_tgt = 32'h8000_1000;
    step();
    branch = 1'b0;
    total++; if (valid !== 1'b0 || imem_addr !== 32'h8000_1000 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL branch_squash: got valid=%b addr=%h req=%b want 0/80001000/1", valid, imem_addr, imem_req); end
    step();
    total++; if (valid !== 1'b1 || pc !== 32'h8000_1000 || inst !== ~32'h8000_1000 || imem_addr !== 32'h8000_1004) begin bad++; $display("[TB] FAIL branch_tgt_inst: got valid=%b pc=%h inst=%h addr=%h", valid, pc, inst, imem_addr); end
  endtask

  task automatic test_branch_outstanding();
    imem_ack = 1'b0;
    step();
    total++; if (imem_addr !== 32'h8000_1004 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL wait_hold: got addr=%h req=%b want 80001004/1", imem_addr, imem_req); end
    branch = 1'b1; branch_tgt = 32'h8000_2003;
    step();
    total++; if (valid !== 1'b0 || imem_addr !== 32'h8000_1004 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL discard_enter: got valid=%b addr=%h req=%b want 0/80001004/1", valid, imem_addr, imem_req); end
    branch_tgt = 32'h8000_3002;
    step();
    branch = 1'b0;
    step();
    total++; if (valid !== 1'b0 || imem_addr !== 32'h8000_1004 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL discard_wait: got valid=%b addr=%h req=%b want 0/80001004/1", valid, imem_addr, imem_req); end
    imem_ack = 1'b1;
    step();
    total++; if (valid !== 1'b0 || imem_addr !== 32'h8000_3000) begin bad++; $display("[TB] FAIL discard_done: got valid=%b addr=%h want 0/80003000", valid, imem_addr); end
    step();
    total++; if (valid !== 1'b1 || pc !== 32'h8000_3000 || imem_addr !== 32'h8000_3004) begin bad++; $display("[TB] FAIL discard_resume: got valid=%b pc=%h addr=%h want 1/80003000/80003004", valid, pc, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (valid !== 1'b1 || pc !== 32'h8000_3000 || inst !== ~32'h8000_3000 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_hold%0d: got valid=%b pc=%h inst=%h req=%b", i, valid, pc, inst, imem_req); end
    end
    stall = 1'b0;
    step();
    total++; if (valid !== 1'b1 || pc !== 32'h8000_3004 || inst !== ~32'h8000_3004 || imem_req !== 1'b1 || imem_addr !== 32'h8000_3008) begin bad++; $display("[TB] FAIL stall_release: got valid=%b pc=%h req=%b addr=%h", valid, pc, imem_req, imem_addr); end
    step();
    total++; if (pc !== 32'h8000_3008 || imem_addr !== 32'h8000_300C) begin bad++; $display("[TB] FAIL stall_resume: got pc=%h addr=%h want 80003008/8000300c", pc, imem_addr); end
  endtask

  task automatic test_exception();
    exception = 1'b1; branch = 1'b1; branch_tgt = 32'h8000_1000;
    step();
    exception = 1'b0; branch = 1'b0;
    total++; if (valid !== 1'b0 || imem_addr !== 32'hBFC0_0380) begin bad++; $display("[TB] FAIL exc_prio: got valid=%b addr=%h want 0/bfc00380", valid, imem_addr); end
    step();
    total++; if (valid !== 1'b1 || pc !== 32'hBFC0_0380) begin bad++; $display("[TB] FAIL exc_inst: got valid=%b pc=%h want 1/bfc00380", valid, pc); end
    stall = 1'b1;
    step();
    exception = 1'b1; branch = 1'b1;
    step();
    exception = 1'b0; branch = 1'b0; stall = 1'b0;
    total++; if (valid !== 1'b0 || imem_addr !== 32'hBFC0_0380 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL exc_stall: got valid=%b addr=%h req=%b want 0/bfc00380/1", valid, imem_addr, imem_req); end
    step();
    total++; if (valid !== 1'b1 || pc !== 32'hBFC0_0380) begin bad++; $display("[TB] FAIL exc_stall_inst: got valid=%b pc=%h want 1/bfc00380", valid, pc); end
  endtask

  task automatic test_wrap();
    branch = 1'b1; branch_tgt = 32'hFFFF_FFFF;
    step();
    branch = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_align: got addr=%h want fffffffc", imem_addr); end
    step();
    total++; if (imem_addr !== 32'h0000_0000 || pc !== 32'hFFFF_FFFC || valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_pc: got addr=%h pc=%h valid=%b want 00000000/fffffffc/1", imem_addr, pc, valid); end
  endtask

  task automatic test_async_reset();
    imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || valid !== 1'b0 || inst !== 32'd0 || pc !== 32'd0 || imem_addr !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL async_reset: got req=%b valid=%b inst=%h pc=%h addr=%h", imem_req, valid, inst, pc, imem_addr); end
    imem_ack = 1'b1; branch = 1'b1; branch_tgt = 32'h8000_1000;
    step(); step();
    branch = 1'b0;
    total++; if (imem_req !== 1'b0 || valid !== 1'b0 || imem_addr !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL reset_no_latch: got req=%b valid=%b addr=%h", imem_req, valid, imem_addr); end
    rst_n = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL post_reset_fetch: got req=%b addr=%h want 1/bfc00000", imem_req, imem_addr); end
    step();
    total++; if (valid !== 1'b1 || pc !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL post_reset_inst: got valid=%b pc=%h want 1/bfc00000", valid, pc); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_branch_outstanding();
    test_stall();
    test_exception();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
